// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I datapath: sequences fetch/decode/
// execute/memory/writeback and drives datapath enables, mux selects and ALUOp.
module multicycle_main_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_e state_q, state_d;
  logic   rdy;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    RegWrite  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = rdy;
        PCWrite   = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch target while decoding
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = rdy;
        if (rdy) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        // ERROR and unused codes park here until reset
        illegal = 1'b1;
        state_d = S_ERROR;
      end
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Table-driven bench: each vector's expectation is queued when driven and
// checked against the DUT on the following falling edge.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, retire, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWrite(RegWrite), .retire(retire), .illegal(illegal), .state(state)
  );

  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic [5:0] q;   // {PCWrite, IRWrite, MemWrite, RegWrite, retire, illegal}
  } vec_t;

  typedef struct {
    int         idx;
    logic [3:0] st;
    logic [5:0] q;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp} expected in each state
  function automatic logic [8:0] moore(input logic [3:0] s);
    case (s)
      4'd0:    return {1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      4'd1:    return {1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      4'd2:    return {1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      4'd3:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd4:    return {1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
      4'd5:    return {1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      4'd6:    return {1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      4'd8:    return {1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      4'd9:    return {1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      4'd10:   return {1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      default: return 9'd0;
    endcase
  endfunction

  function automatic void v(input logic r, input logic [6:0] o, input logic z,
                            input logic rd, input logic [3:0] s, input logic [5:0] q);
    vec_t t;
    t.rst = r; t.op = o; t.zero = z; t.rdy = rd; t.st = s; t.q = q;
    vecs.push_back(t);
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [8:0] m;
      e = sb.pop_front();
      checks++;
      if ({state, PCWrite, IRWrite, MemWrite, RegWrite, retire, illegal} !== {e.st, e.q}) begin
        errors++;
        $display("FAIL ctrl[%0d]: got state=%0d pcw/irw/memw/regw/ret/ill=%b, want state=%0d %b",
                 e.idx, state, {PCWrite, IRWrite, MemWrite, RegWrite, retire, illegal}, e.st, e.q);
      end
      m = moore(e.st);
      checks++;
      if ({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp} !== m) begin
        errors++;
        $display("FAIL mux[%0d]: got adr/res/srca/srcb/aluop=%b, want %b",
                 e.idx, {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}, m);
      end
    end
  end

  initial begin
    // reset, then lw with mem_ready=1: 0,1,2,3,4,0
    v(1, 7'h03, 0, 1, 0,  6'b000000);
    v(0, 7'h03, 0, 1, 0,  6'b110000);
    v(0, 7'h03, 0, 1, 1,  6'b000000);
    v(0, 7'h03, 0, 1, 2,  6'b000000);
    v(0, 7'h03, 0, 1, 3,  6'b000000);
    v(0, 7'h03, 0, 1, 4,  6'b000110);
    // sw with three wait cycles in MEMWRITE
    v(0, 7'h23, 0, 1, 0,  6'b110000);
    v(0, 7'h23, 0, 1, 1,  6'b000000);
    v(0, 7'h23, 0, 1, 2,  6'b000000);
    v(0, 7'h23, 0, 0, 5,  6'b001000);
    v(0, 7'h23, 0, 0, 5,  6'b001000);
    v(0, 7'h23, 0, 0, 5,  6'b001000);
    v(0, 7'h23, 0, 1, 5,  6'b001010);
    // R-type, I-type, jal
    v(0, 7'h33, 0, 1, 0,  6'b110000);
    v(0, 7'h33, 0, 1, 1,  6'b000000);
    v(0, 7'h33, 0, 1, 6,  6'b000000);
    v(0, 7'h33, 0, 1, 7,  6'b000110);
    v(0, 7'h13, 0, 1, 0,  6'b110000);
    v(0, 7'h13, 0, 1, 1,  6'b000000);
    v(0, 7'h13, 0, 1, 8,  6'b000000);
    v(0, 7'h13, 0, 1, 7,  6'b000110);
    v(0, 7'h6F, 0, 1, 0,  6'b110000);
    v(0, 7'h6F, 0, 1, 1,  6'b000000);
    v(0, 7'h6F, 0, 1, 9,  6'b100000);
    v(0, 7'h6F, 0, 1, 7,  6'b000110);
    // beq taken / not taken
    v(0, 7'h63, 1, 1, 0,  6'b110000);
    v(0, 7'h63, 1, 1, 1,  6'b000000);
    v(0, 7'h63, 1, 1, 10, 6'b100010);
    v(0, 7'h63, 0, 1, 0,  6'b110000);
    v(0, 7'h63, 0, 1, 1,  6'b000000);
    v(0, 7'h63, 0, 1, 10, 6'b000010);
    // FETCH waits two cycles; DECODE ignores mem_ready
    v(0, 7'h33, 0, 0, 0,  6'b000000);
    v(0, 7'h33, 0, 0, 0,  6'b000000);
    v(0, 7'h33, 0, 1, 0,  6'b110000);
    v(0, 7'h33, 0, 0, 1,  6'b000000);
    v(0, 7'h33, 0, 0, 6,  6'b000000);
    v(0, 7'h33, 0, 0, 7,  6'b000110);
    // lw with MEMREAD wait; op changes there must be ignored
    v(0, 7'h03, 0, 1, 0,  6'b110000);
    v(0, 7'h03, 0, 1, 1,  6'b000000);
    v(0, 7'h03, 0, 1, 2,  6'b000000);
    v(0, 7'h00, 0, 0, 3,  6'b000000);
    v(0, 7'h23, 0, 1, 3,  6'b000000);
    v(0, 7'h00, 0, 1, 4,  6'b000110);
    // reset asserted in MEMREAD: back to FETCH, no writeback
    v(0, 7'h03, 0, 1, 0,  6'b110000);
    v(0, 7'h03, 0, 1, 1,  6'b000000);
    v(0, 7'h03, 0, 1, 2,  6'b000000);
    v(1, 7'h03, 0, 1, 3,  6'b000000);
    v(0, 7'h03, 0, 1, 0,  6'b110000);
    v(0, 7'h03, 0, 1, 1,  6'b000000);
    // illegal opcode: park in ERROR for 10 cycles, leave only via reset
    v(0, 7'h03, 0, 1, 2,  6'b000000);
    v(0, 7'h03, 0, 1, 3,  6'b000000);
    v(0, 7'h00, 0, 1, 4,  6'b000110);
    v(0, 7'h00, 0, 1, 0,  6'b110000);
    v(0, 7'h00, 0, 1, 1,  6'b000000);
    for (int i = 0; i < 10; i++) v(0, (i % 2) ? 7'h03 : 7'h33, 1, i[0], 11, 6'b000001);
    v(1, 7'h33, 0, 1, 11, 6'b000001);
    v(0, 7'h33, 0, 1, 0,  6'b110000);

    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      exp_t e;
      @(posedge clk);
      #1;
      rst = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
      e.idx = i; e.st = vecs[i].st; e.q = vecs[i].q;
      sb.push_back(e);
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
